exception_sequencer: RTL

Sequences the datapath's exception entry for the multicycle CPU. Latches one exception cause raised by the main control unit, saves the faulting PC into EPC, and drives the 3-bit memory-address mux selector to the handler vector slot (253/254/255). It then waits out memory read latency and loads PC with the zero-extended handler byte. While it runs, it holds the main control unit stalled through `busy`.

---
 rtl/exception_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/exception_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exception_sequencer: latches one exception cause, saves EPC, fetches the    |
// | handler byte from the vector slot and loads it into PC.  Rev 1.0            |
// +----------------------------------------------------------------------------+
module exception_sequencer #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [7:0]  mem_byte,
  output logic [2:0]  addr_sel,
  output logic        mem_read,
  output logic        epc_write,
  output logic        pc_write,
  output logic [31:0] handler_pc,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SAVE_EPC = 3'd1,
    S_FETCH    = 3'd2,
    S_LOAD_PC  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [3:0] C_WAIT_INIT = 4'(MEM_WAIT - 1);

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] handler_q, handler_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cause_q   <= 2'd0;
      cnt_q     <= 4'd0;
      handler_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      handler_q <= handler_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    handler_d = handler_q;
    unique case (state_q)
      S_IDLE: begin
        // Fixed priority; lower-priority simultaneous causes are dropped.
        if (exc_opcode) begin
          cause_d = 2'd1;
          state_d = S_SAVE_EPC;
        end else if (exc_overflow) begin
          cause_d = 2'd2;
          state_d = S_SAVE_EPC;
        end else if (exc_divzero) begin
          cause_d = 2'd3;
          state_d = S_SAVE_EPC;
        end
      end
      S_SAVE_EPC: begin
        cnt_d   = C_WAIT_INIT;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (cnt_q == 4'd0) begin
          handler_d = mem_byte;
          state_d   = S_LOAD_PC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_LOAD_PC: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        cause_d = 2'd0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cause_d = 2'd0;
      end
    endcase
  end

  // Moore outputs; cause is 1..3 during FETCH so the selector stays in 2..4.
  always_comb begin
    addr_sel  = 3'd0;
    mem_read  = 1'b0;
    epc_write = 1'b0;
    pc_write  = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_SAVE_EPC: epc_write = 1'b1;
      S_FETCH: begin
        addr_sel = {1'b0, cause_q} + 3'd1;
        mem_read = 1'b1;
      end
      S_LOAD_PC:  pc_write = 1'b1;
      S_DONE:     done = 1'b1;
      default:    ;
    endcase
  end

  assign handler_pc = {24'd0, handler_q};
  assign cause      = cause_q;

endmodule
`default_nettype wire
